// File: rtl/rs_conv_deinterleaver_if.sv
// ---------------------------------------------------------------------------
// rs_conv_deinterleaver_if
// Byte-stream bundle between the demodulator/sync stage, the convolutional
// deinterleaver and the downstream RS decoder.
//   CE          : one-cycle strobe per input byte
//   input_byte  : interleaved byte, valid while CE=1
//   sync_in     : codeword sync marker, qualified by CE
//   Out_byte    : de-interleaved byte
//   CEO         : one-cycle strobe per valid output byte
//   Valid_out   : level, high while the pipeline is filled and locked
//   sync_out    : pulses with CEO on the first byte of each output codeword
//   sync_err    : one-cycle pulse on a misaligned sync_in
// master = byte source / sink side, slave = deinterleaver side.
// ---------------------------------------------------------------------------
interface rs_conv_deinterleaver_if;
   logic       CE;
   logic [7:0] input_byte;
   logic       sync_in;
   logic [7:0] Out_byte;
   logic       CEO;
   logic       Valid_out;
   logic       sync_out;
   logic       sync_err;

   modport master (
      output CE, input_byte, sync_in,
      input  Out_byte, CEO, Valid_out, sync_out, sync_err
   );
   modport slave (
      input  CE, input_byte, sync_in,
      output Out_byte, CEO, Valid_out, sync_out, sync_err
   );
endinterface

// File: rtl/rs_conv_deinterleaver.sv
// ---------------------------------------------------------------------------
// rs_conv_deinterleaver
// Forney convolutional deinterleaver (I branches, M bytes per branch step)
// feeding an RS decoder. Branch j (0..I-2) is a circular FIFO of
// (I-1-j)*M bytes packed into one shared RAM; branch I-1 is a straight wire.
// Output starts after FILL accepted bytes, which lands on the original sync
// byte so output codewords begin on a codeword boundary.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (RAM contents are not cleared)
//   bus   : rs_conv_deinterleaver_if.slave (CE/input_byte/sync_in in,
//           Out_byte/CEO/Valid_out/sync_out/sync_err out)
// ---------------------------------------------------------------------------
module rs_conv_deinterleaver #(
   parameter int I   = 12,
   parameter int M   = 17,
   parameter int PKT = 204
) (
   input  logic                      clk,
   input  logic                      reset,
   rs_conv_deinterleaver_if.slave    bus
);
   localparam int MEM_DEPTH = M * I * (I - 1) / 2;
   localparam int FILL      = M * I * (I - 1);
   localparam int AW        = $clog2(MEM_DEPTH);
   localparam int BW        = $clog2(I);
   localparam int PW        = $clog2(PKT);
   localparam int FW        = $clog2(FILL + 1);
   localparam int PTW       = $clog2(M * (I - 1));

   typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

   // First RAM address of branch j: M * sum_{k<j} (I-1-k)
   function automatic int base_of(input int j);
      return M * (j * (I - 1) - (j * (j - 1)) / 2);
   endfunction

   state_t           r_state, w_state_next;
   logic             w_accept, w_resync;
   logic [BW-1:0]    r_b, w_b_eff;
   logic [PW-1:0]    r_p, w_p_eff;
   logic [FW-1:0]    r_f, w_f_eff;
   logic [PTW-1:0]   w_ptr_tab [0:I-2];
   logic [PTW-1:0]   w_ptr_cur;
   logic [AW-1:0]    w_base, w_addr;
   logic             w_delayed;

   logic [7:0]       r_mem [0:MEM_DEPTH-1];
   logic [7:0]       r_ram_q;
   logic [7:0]       r_byp, r_out_hold, w_out_data;
   logic             r_use_byp, r_ceo, r_valid, r_sync_out, r_sync_err;

   // ---------------- lock FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_UNLOCKED;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_resync     = 1'b0;
      case (r_state)
         ST_UNLOCKED: begin
            // Counters and pointers are already zero here, so the sync byte
            // is naturally processed as branch 0.
            if (bus.CE && bus.sync_in) begin
               w_state_next = ST_LOCKED;
               w_accept     = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (bus.CE) begin
               w_accept = 1'b1;
               if (bus.sync_in && ((r_b != '0) || (r_p != '0))) w_resync = 1'b1;
            end
         end
         default: w_state_next = ST_UNLOCKED;
      endcase
   end

   // A misaligned sync restarts everything at this very byte.
   assign w_b_eff = w_resync ? '0 : r_b;
   assign w_p_eff = w_resync ? '0 : r_p;
   assign w_f_eff = w_resync ? '0 : r_f;

   // ---------------- branch pointers ----------------
   for (genvar gi = 0; gi < I - 1; gi++) begin : g_branch
      localparam int L = (I - 1 - gi) * M;
      logic [PTW-1:0] r_ptr;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            r_ptr <= '0;
         else if (w_accept && (w_b_eff == BW'(gi)))
            r_ptr <= (w_ptr_cur == PTW'(L - 1)) ? '0 : w_ptr_cur + PTW'(1);
         else if (w_resync)
            r_ptr <= '0;
      end
      assign w_ptr_tab[gi] = r_ptr;
   end

   always_comb begin
      w_base    = '0;
      w_ptr_cur = '0;
      for (int k = 0; k < I - 1; k++) begin
         if (w_b_eff == BW'(k)) begin
            w_base    = AW'(base_of(k));
            w_ptr_cur = w_ptr_tab[k];
         end
      end
      if (w_resync) w_ptr_cur = '0;
   end

   assign w_addr    = w_base + AW'(w_ptr_cur);
   assign w_delayed = (w_b_eff != BW'(I - 1));

   // ---------------- storage: read-first single-port RAM ----------------
   always_ff @(posedge clk) begin
      if (w_accept && w_delayed) begin
         r_ram_q        <= r_mem[w_addr];
         r_mem[w_addr]  <= bus.input_byte;
      end
   end

   // ---------------- counters ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_b <= '0;
         r_p <= '0;
         r_f <= '0;
      end else if (w_accept) begin
         r_b <= (w_b_eff == BW'(I - 1))   ? '0 : w_b_eff + BW'(1);
         r_p <= (w_p_eff == PW'(PKT - 1)) ? '0 : w_p_eff + PW'(1);
         r_f <= (w_f_eff == FW'(FILL))    ? w_f_eff : w_f_eff + FW'(1);
      end
   end

   // ---------------- outputs ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ceo      <= 1'b0;
         r_valid    <= 1'b0;
         r_sync_out <= 1'b0;
         r_sync_err <= 1'b0;
         r_use_byp  <= 1'b0;
         r_byp      <= '0;
         r_out_hold <= '0;
      end else begin
         r_ceo      <= 1'b0;
         r_sync_out <= 1'b0;
         r_sync_err <= 1'b0;
         if (r_ceo) r_out_hold <= w_out_data;
         if (w_accept) begin
            r_sync_err <= w_resync;
            r_use_byp  <= !w_delayed;
            r_byp      <= bus.input_byte;
            if (w_resync) r_valid <= 1'b0;
            if (w_f_eff == FW'(FILL)) begin
               r_ceo      <= 1'b1;
               r_valid    <= 1'b1;
               r_sync_out <= (w_b_eff == '0) && (w_p_eff == '0);
            end
         end
      end
   end

   // RAM output is only presented during the CEO cycle; otherwise the last
   // delivered byte (reset to 0) is held so the RAM needs no reset.
   assign w_out_data    = r_use_byp ? r_byp : r_ram_q;
   assign bus.Out_byte  = r_ceo ? w_out_data : r_out_hold;
   assign bus.CEO       = r_ceo;
   assign bus.Valid_out = r_valid;
   assign bus.sync_out  = r_sync_out;
   assign bus.sync_err  = r_sync_err;
endmodule

// File: tb/tb_rs_conv_deinterleaver.sv
// ---------------------------------------------------------------------------
// tb_rs_conv_deinterleaver
// Self-checking bench: a vector table for lock/unlock/sync behaviour, then
// streamed sequences (end-to-end, pointer wrap, misaligned sync, async reset).
// The interleaved stream is generated in closed form: interleaver branch j
// delays by j*M*I bytes, so in[n] = orig[n - 204*(n mod 12)].
// ---------------------------------------------------------------------------
module tb_rs_conv_deinterleaver;
   localparam int FILL = 2244;
   localparam int PKT  = 204;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   rs_conv_deinterleaver_if bus ();

   rs_conv_deinterleaver dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       ce;
      logic       sync;
      logic [7:0] d;
      logic       exp_ceo;
      logic       exp_valid;
      logic       exp_so;
      logic       exp_err;
      logic [7:0] exp_out;
   } vec_t;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s idx=%0d got=%0h expected=%0h", name, idx, act, exp);
      end
   endtask

   function automatic logic [7:0] orig_byte(input int n);
      int k;
      k = n % PKT;
      return (k == 0) ? 8'h47 : 8'(k);
   endfunction

   function automatic logic [7:0] il_byte(input int n);
      int src;
      src = n - PKT * (n % 12);
      return (src < 0) ? 8'h00 : orig_byte(src);
   endfunction

   // One input slot: drive for one clock, sample outputs on the next negedge.
   task automatic send(input logic ce, input logic [7:0] d, input logic s, input int gap,
                       output logic ceo, output logic [7:0] ob, output logic so,
                       output logic vo, output logic er);
      @(negedge clk);
      bus.CE = ce; bus.input_byte = d; bus.sync_in = s;
      @(negedge clk);
      bus.CE = 1'b0; bus.sync_in = 1'b0; bus.input_byte = 8'h00;
      ceo = bus.CEO; ob = bus.Out_byte; so = bus.sync_out; vo = bus.Valid_out; er = bus.sync_err;
      for (int g = 2; g < gap; g++) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   // Aligned stream byte n (lock at n=0): checks fill behaviour and
   // end-to-end recovery of the original codeword stream.
   task automatic stream_byte(input int n, input int gap, input string tag);
      logic ceo, so, vo, er;
      logic [7:0] ob;
      send(1'b1, il_byte(n), (n % PKT) == 0, gap, ceo, ob, so, vo, er);
      chk({tag, "_err"}, n, er, 0);
      if (n < FILL) begin
         chk({tag, "_prefill_ceo"}, n, ceo, 0);
         chk({tag, "_prefill_valid"}, n, vo, 0);
         chk({tag, "_prefill_out"}, n, ob, 0);
      end else begin
         chk({tag, "_ceo"}, n, ceo, 1);
         chk({tag, "_valid"}, n, vo, 1);
         chk({tag, "_out"}, n, ob, orig_byte(n - FILL));
         chk({tag, "_sync_out"}, n, so, ((n - FILL) % PKT) == 0);
      end
      if ((n % PKT) == PKT - 1)
         $display("[TB] %s codeword %0d fed (last out=%02h ceo=%0b)", tag, n / PKT, ob, ceo);
   endtask

   vec_t vt [9];

   initial begin
      #5_000_000;
      $display("FAIL watchdog idx=0 got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ceo, so, vo, er;
      logic [7:0] ob;
      int s_idx;

      bus.CE = 1'b0; bus.input_byte = 8'h00; bus.sync_in = 1'b0;

      //              ce    sync  d      ceo   valid so    err   out
      vt[0] = '{1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // unlocked, ignored
      vt[1] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // sync w/o CE
      vt[2] = '{1'b1, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // lock, b=0
      vt[3] = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // b=1
      vt[4] = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}; // b=2 -> misaligned
      vt[5] = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}; // b=1 -> misaligned
      vt[6] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // ignored
      vt[7] = '{1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // b=1
      vt[8] = '{1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}; // b=2 -> misaligned

      // ---------- reset state ----------
      repeat (2) @(negedge clk);
      chk("rst_ceo", 0, bus.CEO, 0);
      chk("rst_valid", 0, bus.Valid_out, 0);
      chk("rst_out", 0, bus.Out_byte, 0);
      reset = 1'b1;

      // ---------- vector table ----------
      foreach (vt[i]) begin
         send(vt[i].ce, vt[i].d, vt[i].sync, 2, ceo, ob, so, vo, er);
         chk("tbl_ceo", i, ceo, vt[i].exp_ceo);
         chk("tbl_valid", i, vo, vt[i].exp_valid);
         chk("tbl_sync_out", i, so, vt[i].exp_so);
         chk("tbl_sync_err", i, er, vt[i].exp_err);
         chk("tbl_out", i, ob, vt[i].exp_out);
         $display("[TB] vec %0d ce=%0b sync=%0b d=%02h -> ceo=%0b valid=%0b so=%0b err=%0b out=%02h",
                  i, vt[i].ce, vt[i].sync, vt[i].d, ceo, vo, so, er, ob);
      end

      // ---------- scenario 1: held reset, then unsynced bytes ----------
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         bus.CE = i[0]; bus.sync_in = i[1]; bus.input_byte = 8'(i * 37);
         chk("inrst_ceo", i, bus.CEO, 0);
         chk("inrst_err", i, bus.sync_err, 0);
         chk("inrst_valid", i, bus.Valid_out, 0);
      end
      @(negedge clk);
      bus.CE = 1'b0; bus.sync_in = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 500; i++) begin
         send(1'b1, 8'(i), 1'b0, 2, ceo, ob, so, vo, er);
         chk("unlocked_ceo", i, ceo, 0);
         chk("unlocked_valid", i, vo, 0);
         chk("unlocked_err", i, er, 0);
      end
      $display("[TB] scenario 1: 500 unsynced bytes fed");

      // ---------- scenarios 2,3,6: long aligned stream, sync on every p=0 ----------
      for (int n = 0; n < 66 * PKT; n++)
         stream_byte(n, (n < 300) ? 8 : 2, "s2");

      // ---------- scenario 4: misaligned sync at p=100 ----------
      for (int n = 66 * PKT; n < 66 * PKT + 100; n++)
         stream_byte(n, 2, "s4pre");
      s_idx = 66 * PKT + 100;
      send(1'b1, il_byte(s_idx), 1'b1, 2, ceo, ob, so, vo, er);
      chk("mis_sync_err", s_idx, er, 1);
      chk("mis_valid", s_idx, vo, 0);
      chk("mis_ceo", s_idx, ceo, 0);
      $display("[TB] misaligned sync at n=%0d -> err=%0b valid=%0b", s_idx, er, vo);
      for (int m = 1; m < FILL; m++) begin
         send(1'b1, il_byte(s_idx + m), 1'b0, 2, ceo, ob, so, vo, er);
         chk("mis_fill_ceo", m, ceo, 0);
         chk("mis_fill_valid", m, vo, 0);
      end
      for (int m = FILL; m < FILL + 36; m++) begin
         send(1'b1, il_byte(s_idx + m), 1'b0, 2, ceo, ob, so, vo, er);
         chk("mis_resume_ceo", m, ceo, 1);
         chk("mis_resume_valid", m, vo, 1);
         chk("mis_resume_so", m, so, (m % PKT) == 0);
         // deinterleaver branch j = m mod 12 delays by (11-j)*204 bytes
         chk("mis_resume_out", m, ob, il_byte(s_idx + m - (11 - (m % 12)) * PKT));
         if (m == FILL) begin
            chk("mis_first_out", m, ob, il_byte(s_idx));
            $display("[TB] resume after resync: out=%02h so=%0b", ob, so);
         end
      end

      // ---------- scenario 5: async reset mid-codeword ----------
      do_reset();
      for (int n = 0; n <= FILL + 3 * PKT + 50; n++)
         stream_byte(n, 2, "s5a");
      reset = 1'b0;   // mid-cycle, away from any rising edge
      #1;
      chk("arst_ceo", 0, bus.CEO, 0);
      chk("arst_valid", 0, bus.Valid_out, 0);
      chk("arst_sync_out", 0, bus.sync_out, 0);
      chk("arst_err", 0, bus.sync_err, 0);
      chk("arst_out", 0, bus.Out_byte, 0);
      $display("[TB] async reset: ceo=%0b valid=%0b out=%02h", bus.CEO, bus.Valid_out, bus.Out_byte);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int n = 0; n < FILL + 2 * PKT; n++)
         stream_byte(n, 2, "s5b");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
